// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered 32-bit ALU with a multi-cycle, one-bit-per-cycle
// shifter for SLL/SRL. Logic ops, add, subtract and LUI finish one cycle
// after start. A shift by k > 0 keeps busy high for k cycles and then
// pulses done.
// Optional feature macro: ALU_OVERFLOW_DETECT_EN adds a registered Overflow
// output that flags signed overflow on ADD/SUB.
module alu_exec_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             ALUOperation,
    input  logic [DATA_WIDTH-1:0]  A,
    input  logic [DATA_WIDTH-1:0]  B,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic [DATA_WIDTH-1:0]  ALUResult,
    output logic                   Zero,
    output logic                   done,
    output logic                   busy,
`ifdef ALU_OVERFLOW_DETECT_EN
    output logic                   Overflow,
`endif
    output logic                   op_error
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_LUI = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;

    localparam int HALF_WIDTH = DATA_WIDTH / 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d;
    logic                   zero_q, zero_d;
    logic                   op_error_q, op_error_d;
    logic [DATA_WIDTH-1:0]  work_q, work_d;
    logic [SHAMT_WIDTH-1:0] count_q, count_d;
    logic                   dir_left_q, dir_left_d;
`ifdef ALU_OVERFLOW_DETECT_EN
    logic                   ovf_q, ovf_d;
    logic                   op_ovf;
`endif

    logic                   accept;
    logic                   start_shift;
    logic                   op_supported;
    logic                   op_is_shift;
    logic [DATA_WIDTH-1:0]  op_res;
    logic [DATA_WIDTH-1:0]  sum;
    logic [DATA_WIDTH-1:0]  diff;
    logic [DATA_WIDTH-1:0]  work_shifted;
    logic                   last_shift;

    // A request is only taken when no shift is in flight; SHIFT ignores start.
    assign accept      = start && (state_q != ST_SHIFT);
    assign start_shift = op_is_shift && (shamt != '0);

    // Add and subtract wrap modulo 2^DATA_WIDTH; carry/borrow are dropped.
    assign sum  = A + B;
    assign diff = A - B;

    // One-bit step of the iterative shifter, direction latched at accept.
    assign work_shifted = dir_left_q ? (work_q << 1) : (work_q >> 1);
    assign last_shift   = (count_q == SHAMT_WIDTH'(1));

    // Decode the opcode into a single-cycle result and classification flags.
    always_comb begin
        op_res       = '0;
        op_supported = 1'b1;
        op_is_shift  = 1'b0;
`ifdef ALU_OVERFLOW_DETECT_EN
        op_ovf       = 1'b0;
`endif
        case (ALUOperation)
            OP_AND: op_res = A & B;
            OP_OR:  op_res = A | B;
            OP_NOR: op_res = ~(A | B);
            OP_ADD: begin
                op_res = sum;
`ifdef ALU_OVERFLOW_DETECT_EN
                op_ovf = (A[DATA_WIDTH-1] == B[DATA_WIDTH-1]) &&
                         (sum[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
`endif
            end
            OP_SUB: begin
                op_res = diff;
`ifdef ALU_OVERFLOW_DETECT_EN
                op_ovf = (A[DATA_WIDTH-1] != B[DATA_WIDTH-1]) &&
                         (diff[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
`endif
            end
            OP_LUI: op_res = {B[HALF_WIDTH-1:0], {HALF_WIDTH{1'b0}}};
            OP_SLL, OP_SRL: begin
                // A zero shift amount completes immediately with B unchanged.
                op_is_shift = 1'b1;
                op_res      = B;
            end
            default: begin
                op_supported = 1'b0;
                op_res       = '0;
            end
        endcase
    end

    // FSM state register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: DONE lasts one cycle unless a new op is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d = start_shift ? ST_SHIFT : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_shift) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: done marks the single cycle a new result is presented.
    always_comb begin
        done = (state_q == ST_DONE);
        busy = (state_q == ST_SHIFT);
    end

    // Datapath next values; visible outputs change only when an op completes.
    always_comb begin
        result_d   = result_q;
        zero_d     = zero_q;
        op_error_d = op_error_q;
        work_d     = work_q;
        count_d    = count_q;
        dir_left_d = dir_left_q;
`ifdef ALU_OVERFLOW_DETECT_EN
        ovf_d      = ovf_q;
`endif
        if (accept) begin
            if (start_shift) begin
                work_d     = B;
                count_d    = shamt;
                dir_left_d = (ALUOperation == OP_SLL);
            end else begin
                result_d   = op_res;
                zero_d     = (op_res == '0);
                op_error_d = ~op_supported;
`ifdef ALU_OVERFLOW_DETECT_EN
                ovf_d      = op_ovf;
`endif
            end
        end else if (state_q == ST_SHIFT) begin
            work_d  = work_shifted;
            count_d = count_q - SHAMT_WIDTH'(1);
            if (last_shift) begin
                result_d   = work_shifted;
                zero_d     = (work_shifted == '0);
                op_error_d = 1'b0;
`ifdef ALU_OVERFLOW_DETECT_EN
                ovf_d      = 1'b0;
`endif
            end
        end
    end

    // Datapath registers; reset presents a zero result with Zero set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q   <= '0;
            zero_q     <= 1'b1;
            op_error_q <= 1'b0;
            work_q     <= '0;
            count_q    <= '0;
            dir_left_q <= 1'b0;
`ifdef ALU_OVERFLOW_DETECT_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            result_q   <= result_d;
            zero_q     <= zero_d;
            op_error_q <= op_error_d;
            work_q     <= work_d;
            count_q    <= count_d;
            dir_left_q <= dir_left_d;
`ifdef ALU_OVERFLOW_DETECT_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign op_error  = op_error_q;
`ifdef ALU_OVERFLOW_DETECT_EN
    assign Overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed-vector bench for alu_exec_unit with
// hand-computed expected results, latencies and busy-cycle counts.
// Define ALU_OVERFLOW_DETECT_EN to also check the Overflow output.
module tb_alu_exec_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  ALUOperation;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  shamt;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        done;
    logic        busy;
    logic        op_error;
`ifdef ALU_OVERFLOW_DETECT_EN
    logic        Overflow;
`endif

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(
        .DATA_WIDTH (32),
        .SHAMT_WIDTH(5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ALUOperation(ALUOperation),
        .A           (A),
        .B           (B),
        .shamt       (shamt),
        .ALUResult   (ALUResult),
        .Zero        (Zero),
        .done        (done),
        .busy        (busy),
`ifdef ALU_OVERFLOW_DETECT_EN
        .Overflow    (Overflow),
`endif
        .op_error    (op_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_res"},  ALUResult, 32'h0);
        check({tag, "_zero"}, {31'b0, Zero}, 32'd1);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_err"},  {31'b0, op_error}, 32'd0);
`ifdef ALU_OVERFLOW_DETECT_EN
        check({tag, "_ovf"},  {31'b0, Overflow}, 32'd0);
`endif
    endtask

    // Issue one op, wait (bounded) for done, then check result, latency,
    // busy-cycle count and flags. Optionally pulses start mid-shift.
    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input logic [31:0] exp_res,
                          input int exp_lat, input logic exp_err,
                          input logic exp_ovf, input bit mid_start);
        logic [31:0] prev_res;
        int lat;
        int busy_cnt;
        prev_res     = ALUResult;
        ALUOperation = op;
        A            = a;
        B            = b;
        shamt        = sh;
        start        = 1'b1;
        tick();
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 64) begin
            if (busy === 1'b1) busy_cnt++;
            check({name, "_hold"}, ALUResult, prev_res);
            if (mid_start && lat == 2) begin
                ALUOperation = 4'b0000;
                A            = 32'hFFFF_FFFF;
                B            = 32'hFFFF_FFFF;
                start        = 1'b1;
            end
            tick();
            start = 1'b0;
            lat++;
        end
        check({name, "_lat"},  32'(lat), 32'(exp_lat));
        check({name, "_busy"}, 32'(busy_cnt), 32'(exp_lat - 1));
        check({name, "_res"},  ALUResult, exp_res);
        check({name, "_zero"}, {31'b0, Zero}, {31'b0, (exp_res == 32'h0)});
        check({name, "_err"},  {31'b0, op_error}, {31'b0, exp_err});
`ifdef ALU_OVERFLOW_DETECT_EN
        check({name, "_ovf"},  {31'b0, Overflow}, {31'b0, exp_ovf});
`else
        if (exp_ovf) begin end
`endif
        $display("op %s opc=%b A=%h B=%h shamt=%0d -> res=%h zero=%b err=%b lat=%0d busy=%0d",
                 name, op, a, b, sh, ALUResult, Zero, op_error, lat, busy_cnt);
        tick();
        check({name, "_doneclr"}, {31'b0, done}, 32'd0);
        check({name, "_after"},   ALUResult, exp_res);
    endtask

    initial begin
        int done_seen;
        reset        = 1'b1;
        start        = 1'b0;
        ALUOperation = 4'b0000;
        A            = '0;
        B            = '0;
        shamt        = '0;

        // Reset values apply before any clock edge and persist across edges.
        #2;
        check_reset_outputs("rst_async");
        tick();
        tick();
        check_reset_outputs("rst_held");
        reset = 1'b0;
        tick();
        check_reset_outputs("rst_idle");

        run_op("add_ovf",  4'b0011, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 1, 1'b0, 1'b1, 1'b0);
        run_op("add_wrap", 4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000, 1, 1'b0, 1'b0, 1'b0);
        run_op("sub_eq",   4'b1000, 32'h1234_5678, 32'h1234_5678, 5'd0, 32'h0000_0000, 1, 1'b0, 1'b0, 1'b0);
        run_op("sub_ovf",  4'b1000, 32'h8000_0000, 32'h0000_0001, 5'd0, 32'h7FFF_FFFF, 1, 1'b0, 1'b1, 1'b0);
        run_op("sub_neg",  4'b1000, 32'h0000_0000, 32'h0000_0001, 5'd0, 32'hFFFF_FFFF, 1, 1'b0, 1'b0, 1'b0);
        run_op("lui",      4'b0101, 32'h0000_0000, 32'h0000_ABCD, 5'd0, 32'hABCD_0000, 1, 1'b0, 1'b0, 1'b0);
        run_op("or",       4'b0001, 32'h0F0F_0000, 32'h0000_00F0, 5'd0, 32'h0F0F_00F0, 1, 1'b0, 1'b0, 1'b0);
        run_op("nor",      4'b0010, 32'h0F0F_0F0F, 32'h0000_F0F0, 5'd0, 32'hF0F0_0000, 1, 1'b0, 1'b0, 1'b0);
        run_op("srl4",     4'b0111, 32'h0000_0000, 32'h8000_0000, 5'd4, 32'h0800_0000, 5, 1'b0, 1'b0, 1'b1);
        run_op("sll0",     4'b0110, 32'h0000_0000, 32'h0000_0001, 5'd0, 32'h0000_0001, 1, 1'b0, 1'b0, 1'b0);
        run_op("bad1010",  4'b1010, 32'h1111_1111, 32'h2222_2222, 5'd0, 32'h0000_0000, 1, 1'b1, 1'b0, 1'b0);
        run_op("and",      4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1, 1'b0, 1'b0, 1'b0);
        run_op("bad0100",  4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h0000_0000, 1, 1'b1, 1'b0, 1'b0);
        run_op("sll31",    4'b0110, 32'h0000_0000, 32'h0000_0003, 5'd31, 32'h8000_0000, 32, 1'b0, 1'b0, 1'b0);
        run_op("srl31",    4'b0111, 32'h0000_0000, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 32, 1'b0, 1'b0, 1'b0);
        run_op("sll3",     4'b0110, 32'h0000_0000, 32'h0000_0011, 5'd3, 32'h0000_0088, 4, 1'b0, 1'b0, 1'b0);

        // Back-to-back single-cycle ops: start held through DONE.
        ALUOperation = 4'b0011;
        A            = 32'h0000_0010;
        B            = 32'h0000_0020;
        start        = 1'b1;
        tick();
        check("b2b_first_done", {31'b0, done}, 32'd1);
        check("b2b_first_res",  ALUResult, 32'h0000_0030);
        ALUOperation = 4'b1000;
        A            = 32'h0000_0100;
        B            = 32'h0000_0001;
        tick();
        start = 1'b0;
        check("b2b_second_done", {31'b0, done}, 32'd1);
        check("b2b_second_res",  ALUResult, 32'h0000_00FF);
        $display("op b2b add->sub res=%h done=%b", ALUResult, done);
        tick();
        check("b2b_doneclr", {31'b0, done}, 32'd0);

        // Reset asserted during busy cycle 3 of SLL by 20 aborts the op.
        ALUOperation = 4'b0110;
        B            = 32'h0000_0001;
        shamt        = 5'd20;
        start        = 1'b1;
        tick();
        start = 1'b0;
        check("abort_busy1", {31'b0, busy}, 32'd1);
        tick();
        tick();
        check("abort_busy3", {31'b0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("abort_rst");
        tick();
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        check_reset_outputs("abort_after");
        $display("op abort sll20 res=%h done_or_busy_cycles=%0d", ALUResult, done_seen);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
